// File: rtl/writeback_arbiter_pkg.sv
// Shared types and constants for the writeback stage.
// Register-write request bundle and load size encoding.
package writeback_arbiter_pkg;

  localparam int XLEN    = 32;
  localparam int NB_REGS = 5;

  localparam logic [NB_REGS-1:0] REG_ZERO = '0;

  typedef enum logic [1:0] {
    LS_BYTE = 2'b00,
    LS_HALF = 2'b01,
    LS_WORD = 2'b10
  } ls_size_e;

  typedef struct packed {
    logic [NB_REGS-1:0] rd;
    logic [XLEN-1:0]    data;
  } wb_req_t;

endpackage

// File: rtl/wb_fifo.sv
// Circular FIFO of writeback requests.
// Full/empty come from the registered count; DEPTH = 1 is supported.
module wb_fifo
  import writeback_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  wb_req_t                      din,
  input  logic                         pop,
  output wb_req_t                      dout,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  wb_req_t       mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  // A full FIFO refuses a push even when a pop happens this cycle.
  assign do_push = push & (count < CW'(DEPTH));
  assign do_pop  = pop & (count != '0);
  assign dout    = mem[rd_ptr];

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Storage write; contents are don't-care while empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointer and occupancy update.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/writeback_arbiter.sv
// Final stage: merges ALU and load results onto the regfile write port.
// Loads win unless the ALU FIFO has been starved for STARVE_MAX cycles.
module writeback_arbiter
  import writeback_arbiter_pkg::*;
#(
  parameter int ALU_FIFO_DEPTH = 2,
  parameter int STARVE_MAX     = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               alu_valid_i,
  output logic               alu_ready_o,
  input  logic [NB_REGS-1:0] alu_rd_i,
  input  logic [XLEN-1:0]    alu_data_i,
  input  logic               lsu_valid_i,
  output logic               lsu_ready_o,
  input  logic [NB_REGS-1:0] lsu_rd_i,
  input  logic [XLEN-1:0]    lsu_rdata_i,
  input  logic [1:0]         lsu_size_i,
  input  logic               lsu_unsigned_i,
  input  logic [1:0]         lsu_offset_i,
  output logic               write_valid_o,
  output logic [NB_REGS-1:0] write_adr_o,
  output logic [XLEN-1:0]    write_data_o,
  output logic               retire_o
);

  localparam int CW = $clog2(ALU_FIFO_DEPTH + 1);
  localparam int SW = $clog2(STARVE_MAX + 1);

  wb_req_t       fifo_din;
  wb_req_t       fifo_dout;
  logic [CW-1:0] fifo_count;
  logic          fifo_empty;
  wb_req_t       hold;
  logic          hold_valid;
  logic [SW-1:0] starve_cnt;
  logic          lsu_grant;
  logic          alu_grant;
  logic          grant;
  wb_req_t       winner;

  function automatic logic [XLEN-1:0] format_load(
    input logic [XLEN-1:0] w,
    input logic [1:0]      size,
    input logic            uns,
    input logic [1:0]      off
  );
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{off, 3'b000} +: 8];
    h = w[{off[1], 4'b0000} +: 16];
    case (ls_size_e'(size))
      LS_BYTE: return {{(XLEN-8){~uns & b[7]}}, b};
      LS_HALF: return {{(XLEN-16){~uns & h[15]}}, h};
      default: return w;
    endcase
  endfunction

  assign alu_ready_o = fifo_count < CW'(ALU_FIFO_DEPTH);
  assign lsu_ready_o = ~hold_valid;
  assign fifo_empty  = fifo_count == '0;
  assign fifo_din    = '{rd: alu_rd_i, data: alu_data_i};

  assign lsu_grant = hold_valid & (fifo_empty | (starve_cnt < SW'(STARVE_MAX)));
  assign alu_grant = ~lsu_grant & ~fifo_empty;
  assign grant     = lsu_grant | alu_grant;
  assign winner    = lsu_grant ? hold : fifo_dout;

  wb_fifo #(
    .DEPTH (ALU_FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (alu_valid_i & alu_ready_o),
    .din   (fifo_din),
    .pop   (alu_grant),
    .dout  (fifo_dout),
    .count (fifo_count)
  );

  // One-entry load hold: freed on grant, refilled on a later cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_valid <= 1'b0;
      hold       <= '0;
    end else if (lsu_grant) begin
      hold_valid <= 1'b0;
    end else if (lsu_valid_i & ~hold_valid) begin
      hold_valid <= 1'b1;
      hold.rd    <= lsu_rd_i;
      hold.data  <= format_load(lsu_rdata_i, lsu_size_i,
                                lsu_unsigned_i, lsu_offset_i);
    end
  end

  // Count cycles the ALU loses with work pending, saturating.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (~fifo_empty & ~alu_grant) begin
      if (starve_cnt < SW'(STARVE_MAX)) starve_cnt <= starve_cnt + SW'(1);
    end else begin
      starve_cnt <= '0;
    end
  end

  // Registered commit; x0 writes retire without a regfile write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      write_valid_o <= 1'b0;
      write_adr_o   <= '0;
      write_data_o  <= '0;
      retire_o      <= 1'b0;
    end else begin
      write_valid_o <= grant & (winner.rd != REG_ZERO);
      retire_o      <= grant;
      if (grant) begin
        write_adr_o  <= winner.rd;
        write_data_o <= winner.data;
      end
    end
  end

endmodule
